// File: rtl/aoi_gate_exerciser_pkg.sv
// ============================================================================
// Module      : aoi_test_pkg
// Description : Shared state encoding, sweep constants and the AOI golden
//               function for the AOI gate exerciser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aoi_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } aoi_state_e;

    localparam int         NUM_VECTORS = 16;
    localparam logic [3:0] LAST_VEC    = 4'hF;

    // Vector bit order is {a,b,c,d}; result order is {e,f,g}.
    function automatic logic [2:0] aoi_golden(input logic [3:0] v);
        logic e;
        logic f;
        e = v[3] & v[2];
        f = v[1] & v[0];
        return {e, f, ~(e | f)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aoi_gate_exerciser_golden.sv
// ============================================================================
// Module      : aoi_golden_model
// Description : Combinational expected-response generator for one vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_golden_model
    import aoi_test_pkg::*;
(
    input  logic [3:0] vec_i,
    output logic [2:0] efg_o
);

    assign efg_o = aoi_golden(vec_i);

endmodule

`default_nettype wire

// File: rtl/aoi_gate_exerciser.sv
// ============================================================================
// Module      : aoi_gate_exerciser
// Description : Sweeps all 16 input vectors into an external AOI gate,
//               checks each response and reports errors and pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_gate_exerciser
    import aoi_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             d_o,
    input  logic             e_in_i,
    input  logic             f_in_i,
    input  logic             g_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [3:0]       first_err_vec_o,
    output logic             first_err_valid_o
);

    localparam int                CNT_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  C_SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ERR_W-1:0]  C_ERR_MAX     = {ERR_W{1'b1}};

    aoi_state_e       state_q, state_d;
    logic [3:0]       vec_idx_q, vec_idx_d;
    logic [3:0]       abcd_q, abcd_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fev_q, fev_d;
    logic             fv_q, fv_d;
    logic             pass_q, pass_d;

    logic [2:0]       w_golden;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_inc;

    aoi_golden_model u_golden (
        .vec_i (vec_idx_q),
        .efg_o (w_golden)
    );

    assign w_mismatch = ({e_in_i, f_in_i, g_in_i} != w_golden);
    assign w_err_inc  = (err_q == C_ERR_MAX) ? err_q : err_q + ERR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_idx_q <= 4'd0;
            abcd_q    <= 4'd0;
            settle_q  <= '0;
            err_q     <= '0;
            fev_q     <= 4'd0;
            fv_q      <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            abcd_q    <= abcd_d;
            settle_q  <= settle_d;
            err_q     <= err_d;
            fev_q     <= fev_d;
            fv_q      <= fv_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        abcd_d    = abcd_q;
        settle_d  = settle_q;
        err_d     = err_q;
        fev_d     = fev_q;
        fv_d      = fv_q;
        pass_d    = pass_q;

        // Abort freezes all results and only forces the state back to IDLE.
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = DRIVE;
                        vec_idx_d = 4'd0;
                        err_d     = '0;
                        fv_d      = 1'b0;
                    end
                end
                DRIVE: begin
                    abcd_d   = vec_idx_q;
                    settle_d = C_SETTLE_LOAD;
                    state_d  = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = CHECK;
                    end else begin
                        settle_d = settle_q - CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        err_d = w_err_inc;
                        if (!fv_q) begin
                            fev_d = vec_idx_q;
                            fv_d  = 1'b1;
                        end
                    end
                    if (vec_idx_q == LAST_VEC) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_idx_d = vec_idx_q + 4'd1;
                        state_d   = DRIVE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign {a_o, b_o, c_o, d_o} = abcd_q;
    assign busy_o               = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
    assign done_o               = (state_q == DONE);
    assign pass_o               = pass_q;
    assign err_count_o          = err_q;
    assign first_err_vec_o      = fev_q;
    assign first_err_valid_o    = fv_q;

endmodule

`default_nettype wire

// File: tb/tb_aoi_gate_exerciser.sv
// ============================================================================
// Module      : tb_aoi_gate_exerciser
// Description : Directed bench for the AOI gate exerciser (two parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aoi_gate_exerciser;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    // Instance 1: default parameters
    logic       s1, ab1, a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1, fv1;
    logic [4:0] err1;
    logic [3:0] fev1;
    logic       g_stuck0;

    // Instance 2: no settle window, 2-bit error counter
    logic       s2, ab2, a2, b2, c2, d2, e2, f2, g2, busy2, done2, pass2, fv2;
    logic [1:0] err2;
    logic [3:0] fev2;
    logic       e_force1;

    // Gates under test with fault controls
    assign e1 = a1 & b1;
    assign f1 = c1 & d1;
    assign g1 = g_stuck0 ? 1'b0 : ~((a1 & b1) | (c1 & d1));
    assign e2 = e_force1 ? 1'b1 : (a2 & b2);
    assign f2 = c2 & d2;
    assign g2 = ~((a2 & b2) | (c2 & d2));

    aoi_gate_exerciser dut (
        .clk(clk), .rst_n(rst_n), .start_i(s1), .abort_i(ab1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
        .e_in_i(e1), .f_in_i(f1), .g_in_i(g1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .first_err_vec_o(fev1), .first_err_valid_o(fv1)
    );

    aoi_gate_exerciser #(.SETTLE_CYCLES(0), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(s2), .abort_i(ab2),
        .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2),
        .e_in_i(e2), .f_in_i(f2), .g_in_i(g2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
        .first_err_vec_o(fev2), .first_err_valid_o(fv2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; s1 = 0; ab1 = 0; s2 = 0; ab2 = 0; g_stuck0 = 0; e_force1 = 0;
        #2;
        chk("rst_abcd", {a1, b1, c1, d1}, 4'h0);
        chk("rst_flags", {busy1, done1, pass1, fv1}, 4'b0000);
        chk("rst_err", err1, 5'd0);
        chk("rst_fev", fev1, 4'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: correct gate, default settle -> done in cycle 65, pass
        s1 = 1; tick(); cyc = 1;
        chk("t1_busy", busy1, 1'b1);
        s1 = 0;
        while (done1 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        chk("t1_latency", cyc, 65);
        chk("t1_pass", pass1, 1'b1);
        chk("t1_err", err1, 5'd0);
        chk("t1_fv", fv1, 1'b0);
        tick();
        chk("t1_done_pulse", {done1, busy1}, 2'b00);
        chk("t1_abcd_hold", {a1, b1, c1, d1}, 4'hF);

        // 2: g stuck at 0 -> vectors 0,1,2,4,5,6,8,9,10 fail
        g_stuck0 = 1;
        s1 = 1; tick(); s1 = 0; cyc = 1;
        while (done1 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        chk("t2_latency", cyc, 65);
        chk("t2_err", err1, 5'd9);
        chk("t2_fev", {fv1, fev1}, 5'h10);
        chk("t2_pass", pass1, 1'b0);
        tick();
        g_stuck0 = 0;

        // 4: abort during settle of vector 5 (DRIVE in cycle 21)
        s1 = 1; tick(); s1 = 0; cyc = 1;
        while (cyc < 22) begin tick(); cyc++; end
        chk("t4_pre_busy", busy1, 1'b1);
        ab1 = 1; tick(); ab1 = 0;
        chk("t4_idle", {busy1, done1}, 2'b00);
        chk("t4_abcd", {a1, b1, c1, d1}, 4'h5);
        chk("t4_pass_hold", pass1, 1'b0);
        saw_done = 1'b0;
        repeat (70) begin tick(); if (done1) saw_done = 1'b1; end
        chk("t4_no_done", saw_done, 1'b0);

        // 5: reset during vector 9 (DRIVE in cycle 37) with a faulty gate
        g_stuck0 = 1;
        s1 = 1; tick(); s1 = 0; cyc = 1;
        while (cyc < 38) begin tick(); cyc++; end
        chk("t5_pre_err", err1, 5'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_abcd", {a1, b1, c1, d1}, 4'h0);
        chk("t5_rst_flags", {busy1, done1, pass1, fv1}, 4'b0000);
        chk("t5_rst_err", {err1, fev1}, 9'd0);
        g_stuck0 = 0;
        #1 rst_n = 1'b1;
        tick();
        s1 = 1; tick(); s1 = 0; cyc = 1;
        while (done1 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        chk("t5_latency", cyc, 65);
        chk("t5_clean", {pass1, err1, fv1}, {1'b1, 5'd0, 1'b0});
        tick();

        // 3: e forced high, 2-bit counter saturates at 3
        e_force1 = 1;
        s2 = 1; tick(); s2 = 0; cyc = 1;
        while (done2 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        chk("t3_latency", cyc, 33);
        chk("t3_err_sat", err2, 2'd3);
        chk("t3_fev", {fv2, fev2}, 5'h10);
        chk("t3_pass", pass2, 1'b0);
        tick();
        e_force1 = 0;

        // 6: no settle, start held high through two sweeps
        s2 = 1; tick(); cyc = 1;
        while (done2 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        chk("t6_latency1", cyc, 33);
        tick(); cyc++;
        chk("t6_idle_gap", {busy2, done2}, 2'b00);
        tick(); cyc++;
        chk("t6_restart", busy2, 1'b1);
        while (done2 !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        chk("t6_latency2", cyc, 67);
        chk("t6_clean", {pass2, err2, fv2}, {1'b1, 2'd0, 1'b0});
        s2 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
